irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have clock `clk`, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have reset `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the following MMIO ports:
- `mmio_we`, input, 1 bit: write strobe.
- `mmio_re`, input, 1 bit: read strobe.
- `mmio_addr`, input, 5 bits: byte offset; bits [4:2] select the register.
- `mmio_wdata`, input, 32 bits: write data.
- `mmio_rdata`, output, 32 bits: read data, registered.
REQ-004 The block SHALL have interrupt inputs `ext_irq`, input, 4 bits: level-high external sources 0..3, asynchronous to `clk`.
REQ-005 The block SHALL have the following mask inputs:
- `mstatus_mie`, input, 1 bit: global enable.
- `mie_msie`, `mie_mtie`, `mie_meie`, input, 1 bit each: local enables.
REQ-006 The block SHALL have the following trap handshake ports:
- `trap_ack`, input, 1 bit: the exception unit has taken the presented interrupt.
- `mret`, input, 1 bit: the handler has returned.
REQ-007 The block SHALL have the following request outputs:
- `interrupt`, output, 1 bit: request to the exception unit.
- `irq_cause`, output, 32 bits: mcause value for the request.

Function
REQ-008 The register map SHALL be:
- 0x00 MTIME_LO (RW), 0x04 MTIME_HI (RW).
- 0x08 MTIMECMP_LO (RW), 0x0C MTIMECMP_HI (RW).
- 0x10 MSIP (RW, bit0 only).
- 0x14 EXT_PENDING (RO, bits[3:0]).
- 0x18 EXT_ENABLE (RW, bits[3:0]).
- 0x1C CLAIM (read = claim, write = complete).
REQ-009 `mmio_rdata` SHALL be valid the cycle after `mmio_re`, SHALL hold its value until the next read, and unmapped bits SHALL read 0.
REQ-010 mtime (64 bits) SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to MTIME_LO or MTIME_HI in the same cycle SHALL replace that half with write data and suppress the increment for that cycle.
- The increment SHALL carry from LO to HI.
REQ-011 mtip SHALL be high exactly while the unsigned comparison mtime >= mtimecmp holds, evaluated on registered values.
REQ-012 Each `ext_irq` bit SHALL pass through a 2-flop synchronizer.
- pending[i] SHALL set when the synchronized level is 1, EXT_ENABLE[i]=1 and in_service[i]=0.
- pending[i] SHALL clear only by claim.
REQ-013 A CLAIM read SHALL return id+1 of the lowest-numbered bit of (pending & EXT_ENABLE), or 0 if there is none.
- In the same cycle it SHALL clear that pending bit and set in_service[id].
REQ-014 A CLAIM write of value v in 1..4 SHALL clear in_service[v-1]; other values SHALL be ignored.
REQ-015 meip SHALL equal |(pending & EXT_ENABLE); msip SHALL equal MSIP[0].
REQ-016 The request is eligible when `mstatus_mie` is 1 and any of (meip&mie_meie, msip&mie_msie, mtip&mie_mtie) is 1.
- Priority SHALL be MEI > MSI > MTI.
- `irq_cause` SHALL be {1'b1, 31'd11}, {1'b1, 31'd3} or {1'b1, 31'd7} respectively.
REQ-017 The handshake FSM SHALL have states IDLE, REQ and SERVICE.
- IDLE→REQ: on the cycle after the request becomes eligible, with `irq_cause` latched.
- REQ: `interrupt` SHALL be 1 and `irq_cause` SHALL be stable; REQ→SERVICE on `trap_ack`.
- REQ→IDLE if eligibility drops before `trap_ack`, with `interrupt` deasserted in the same cycle the state changes.
- SERVICE: `interrupt` SHALL be 0; SERVICE→IDLE on `mret`.
REQ-018 A higher-priority source arising in REQ SHALL NOT change `irq_cause` until the FSM returns to IDLE.
REQ-019 `trap_ack` in IDLE or SERVICE, and `mret` in IDLE or REQ, SHALL be ignored.
REQ-020 If `trap_ack` and loss of eligibility occur in the same cycle, `trap_ack` SHALL win (REQ→SERVICE).
REQ-021 After SERVICE→IDLE, a still-eligible request SHALL re-raise `interrupt` no earlier than 2 cycles after `mret`.

Reset
REQ-022 On `rst`, the block SHALL asynchronously clear:
- mtime, MSIP, EXT_ENABLE, pending and in_service to 0.
- the synchronizers to 0.
- the FSM to IDLE.
- `interrupt` to 0, `irq_cause` to 0 and `mmio_rdata` to 0.
REQ-023 On `rst`, mtimecmp SHALL reset to 0xFFFF_FFFF_FFFF_FFFF so that no timer interrupt fires at reset.
REQ-024 `rst` asserted in REQ or SERVICE SHALL abort the handshake with no further `interrupt` pulse until a request is eligible again after reset.

Verification
REQ-025 Timer: set mtimecmp=0x20, mie_mtie=1, mstatus_mie=1 → `interrupt`=1 with `irq_cause`=0x8000_0007 the cycle after mtime reaches 0x20; `trap_ack` → `interrupt`=0; `mret` → re-raise after 2 cycles.
REQ-026 Priority: MSIP=1 and ext_irq[2]=1 with enable[2]=1, all local enables 1 → `irq_cause`=0x8000_000B; CLAIM read returns 3; after complete and MSIP still set, next request has cause 0x8000_0003.
REQ-027 Claim/complete: ext_irq=4'b0110, enable=4'hF → claims return 2, then 3, then 0; pending bit 1 does not re-set while ext_irq[1] stays high until CLAIM write 2.
REQ-028 Wrap and write collision: write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF → next cycle mtime=0; a write of MTIME_LO=5 in the same cycle as an increment → MTIME_LO reads 5.
REQ-029 Withdraw: in REQ, clear `mstatus_mie` → FSM returns to IDLE and `interrupt` drops with no SERVICE entry; `trap_ack` and withdraw in the same cycle → SERVICE.
REQ-030 Reset mid-SERVICE: assert `rst` → `interrupt`=0, mtimecmp reads 0xFFFF_FFFF on both halves, EXT_PENDING reads 0.

Source files
------------

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: 64-bit mtime/mtimecmp timer, software interrupt,
// four synchronized external sources with claim/complete, and an IDLE/REQ/SERVICE handshake.
module irq_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [4:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic [3:0]  ext_irq,
  input  logic        mstatus_mie,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        interrupt,
  output logic [31:0] irq_cause
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  reg_sel;
  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic [3:0]  ext_enable, sync1, sync2, pending, in_service;
  logic [3:0]  active, pending_next, in_service_next;
  logic        claim_any, claim_rd, claim_wr, complete_ok;
  logic [1:0]  claim_idx, complete_idx;
  logic        mtip, meip, eligible;
  logic [31:0] cause_sel;
  logic        unused_addr;

  assign reg_sel     = mmio_addr[4:2];
  assign unused_addr = ^mmio_addr[1:0];
  assign claim_rd    = mmio_re && (reg_sel == 3'd7);
  assign claim_wr    = mmio_we && (reg_sel == 3'd7);
  assign complete_ok = (mmio_wdata >= 32'd1) && (mmio_wdata <= 32'd4);
  assign complete_idx = mmio_wdata[1:0] - 2'd1;

  // A write to either half replaces it and holds the other half for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (mmio_we && reg_sel == 3'd0) begin
      mtime[31:0] <= mmio_wdata;
    end else if (mmio_we && reg_sel == 3'd1) begin
      mtime[63:32] <= mmio_wdata;
    end else begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp   <= '1;
      msip       <= 1'b0;
      ext_enable <= '0;
    end else if (mmio_we) begin
      case (reg_sel)
        3'd2: mtimecmp[31:0]  <= mmio_wdata;
        3'd3: mtimecmp[63:32] <= mmio_wdata;
        3'd4: msip            <= mmio_wdata[0];
        3'd6: ext_enable      <= mmio_wdata[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ext_irq;
      sync2 <= sync1;
    end
  end

  assign active = pending & ext_enable;

  always_comb begin
    claim_any = 1'b0;
    claim_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (active[i] && !claim_any) begin
        claim_any = 1'b1;
        claim_idx = 2'(i);
      end
    end
  end

  // The claim clear wins over a same-cycle re-set; in_service blocks it afterwards.
  always_comb begin
    pending_next    = pending | (sync2 & ext_enable & ~in_service);
    in_service_next = in_service;
    if (claim_wr && complete_ok) in_service_next[complete_idx] = 1'b0;
    if (claim_rd && claim_any) begin
      pending_next[claim_idx]    = 1'b0;
      in_service_next[claim_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= pending_next;
      in_service <= in_service_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_rdata <= '0;
    end else if (mmio_re) begin
      case (reg_sel)
        3'd0: mmio_rdata <= mtime[31:0];
        3'd1: mmio_rdata <= mtime[63:32];
        3'd2: mmio_rdata <= mtimecmp[31:0];
        3'd3: mmio_rdata <= mtimecmp[63:32];
        3'd4: mmio_rdata <= {31'd0, msip};
        3'd5: mmio_rdata <= {28'd0, pending};
        3'd6: mmio_rdata <= {28'd0, ext_enable};
        default: mmio_rdata <= claim_any ? (32'(claim_idx) + 32'd1) : '0;
      endcase
    end
  end

  assign mtip = (mtime >= mtimecmp);
  assign meip = |active;

  always_comb begin
    eligible  = mstatus_mie && ((meip && mie_meie) || (msip && mie_msie) || (mtip && mie_mtie));
    cause_sel = {1'b1, 31'd7};
    if (meip && mie_meie)      cause_sel = {1'b1, 31'd11};
    else if (msip && mie_msie) cause_sel = {1'b1, 31'd3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eligible) state_d = REQ;
      REQ:     if (trap_ack) state_d = SERVICE;
               else if (!eligible) state_d = IDLE;
      SERVICE: if (mret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    interrupt = (state_q == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_cause <= '0;
    else if (state_q == IDLE && eligible) irq_cause <= cause_sel;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: timer, priority, claim/complete, mtime wrap,
// request withdraw and reset-during-service scenarios with hand-computed expectations.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_we, mmio_re;
  logic [4:0]  mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [3:0]  ext_irq;
  logic        mstatus_mie, mie_msie, mie_mtie, mie_meie;
  logic        trap_ack, mret;
  logic        interrupt;
  logic [31:0] irq_cause;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  irq_controller dut (
    .clk(clk), .rst(rst),
    .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .ext_irq(ext_irq),
    .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .trap_ack(trap_ack), .mret(mret),
    .interrupt(interrupt), .irq_cause(irq_cause)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    step(1);
    mmio_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] expected);
    mmio_re = 1'b1; mmio_addr = a;
    step(1);
    mmio_re = 1'b0;
    check(tag, mmio_rdata, expected);
  endtask

  initial begin
    rst = 1'b1; mmio_we = 1'b0; mmio_re = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    ext_irq = '0; mstatus_mie = 1'b0; mie_msie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0;
    trap_ack = 1'b0; mret = 1'b0;
    step(2);
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check("rst_cause", irq_cause, 32'd0);
    check("rst_rdata", mmio_rdata, 32'd0);
    rst = 1'b0;
    rd_check("rst_cmp_lo", 5'h08, 32'hFFFF_FFFF);
    rd_check("rst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rd_check("rst_pending", 5'h14, 32'd0);
    rd_check("rst_enable", 5'h18, 32'd0);

    // mtime wrap and carry into the high half
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    rd_check("wrap_lo_max", 5'h00, 32'hFFFF_FFFF);
    rd_check("wrap_hi_zero", 5'h04, 32'd0);
    rd_check("wrap_lo_one", 5'h00, 32'd1);
    // write collides with increment
    wr(5'h00, 32'd5);
    rd_check("collide_lo", 5'h00, 32'd5);

    // timer interrupt
    mie_mtie = 1'b1; mstatus_mie = 1'b1;
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'h20);
    wr(5'h00, 32'd0);
    step(31);
    check("tmr_before", {31'd0, interrupt}, 32'd0);
    step(1);
    check("tmr_at_match", {31'd0, interrupt}, 32'd0);
    step(1);
    check("tmr_raise", {31'd0, interrupt}, 32'd1);
    check("tmr_cause", irq_cause, 32'h8000_0007);
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    check("tmr_ack_drop", {31'd0, interrupt}, 32'd0);
    step(3);
    check("tmr_service_low", {31'd0, interrupt}, 32'd0);
    mret = 1'b1; step(1); mret = 1'b0;
    check("tmr_mret_plus1", {31'd0, interrupt}, 32'd0);
    step(1);
    check("tmr_mret_plus2", {31'd0, interrupt}, 32'd1);
    mie_mtie = 1'b0;
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    check("tmr_ack_wins", {31'd0, interrupt}, 32'd0);
    wr(5'h0C, 32'hFFFF_FFFF);
    mret = 1'b1; step(1); mret = 1'b0;
    step(2);
    check("tmr_quiet", {31'd0, interrupt}, 32'd0);

    // withdraw via mstatus_mie
    mie_msie = 1'b1;
    wr(5'h10, 32'd1);
    check("sw_idle", {31'd0, interrupt}, 32'd0);
    step(1);
    check("sw_raise", {31'd0, interrupt}, 32'd1);
    check("sw_cause", irq_cause, 32'h8000_0003);
    mstatus_mie = 1'b0; step(1);
    check("withdraw_drop", {31'd0, interrupt}, 32'd0);
    step(1);
    check("withdraw_idle", {31'd0, interrupt}, 32'd0);
    mstatus_mie = 1'b1; step(1);
    check("withdraw_reraise", {31'd0, interrupt}, 32'd1);
    trap_ack = 1'b1; mstatus_mie = 1'b0; step(1);
    trap_ack = 1'b0; mstatus_mie = 1'b1;
    check("ack_vs_withdraw", {31'd0, interrupt}, 32'd0);
    step(2);
    check("ack_vs_withdraw_service", {31'd0, interrupt}, 32'd0);
    mret = 1'b1; step(1); mret = 1'b0;
    step(1);
    check("sw_after_mret", {31'd0, interrupt}, 32'd1);
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    wr(5'h10, 32'd0);
    mret = 1'b1; step(1); mret = 1'b0;
    step(2);
    check("sw_quiet", {31'd0, interrupt}, 32'd0);

    // priority MEI over MSI, then MSI after completion
    mstatus_mie = 1'b0; mie_meie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1;
    wr(5'h18, 32'h4);
    ext_irq = 4'b0100;
    wr(5'h10, 32'd1);
    step(3);
    mstatus_mie = 1'b1; step(1);
    check("prio_raise", {31'd0, interrupt}, 32'd1);
    check("prio_cause_mei", irq_cause, 32'h8000_000B);
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    rd_check("prio_claim", 5'h1C, 32'd3);
    ext_irq = '0; step(3);
    wr(5'h1C, 32'd3);
    mret = 1'b1; step(1); mret = 1'b0;
    check("prio_mret_plus1", {31'd0, interrupt}, 32'd0);
    step(1);
    check("prio_msi_raise", {31'd0, interrupt}, 32'd1);
    check("prio_cause_msi", irq_cause, 32'h8000_0003);
    ext_irq = 4'b0100; step(5);
    check("prio_cause_stable", irq_cause, 32'h8000_0003);
    check("prio_still_req", {31'd0, interrupt}, 32'd1);
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    rd_check("prio_claim2", 5'h1C, 32'd3);
    ext_irq = '0; mie_mtie = 1'b0;
    wr(5'h10, 32'd0);
    step(3);
    wr(5'h1C, 32'd3);
    mret = 1'b1; step(1); mret = 1'b0;
    step(2);
    check("prio_quiet", {31'd0, interrupt}, 32'd0);

    // claim / complete sequence
    mstatus_mie = 1'b0;
    wr(5'h18, 32'hF);
    ext_irq = 4'b0110;
    step(4);
    rd_check("cc_pending", 5'h14, 32'h6);
    rd_check("cc_claim_a", 5'h1C, 32'd2);
    rd_check("cc_claim_b", 5'h1C, 32'd3);
    rd_check("cc_claim_none", 5'h1C, 32'd0);
    rd_check("cc_no_reset", 5'h14, 32'd0);
    wr(5'h1C, 32'd5);
    wr(5'h1C, 32'd0);
    wr(5'h1C, 32'd2);
    step(1);
    rd_check("cc_complete2", 5'h14, 32'h2);
    step(2);
    check("cc_rdata_hold", mmio_rdata, 32'h2);
    rd_check("cc_enable", 5'h18, 32'hF);
    ext_irq = '0;
    rd_check("cc_claim_c", 5'h1C, 32'd2);
    wr(5'h1C, 32'd2);
    wr(5'h1C, 32'd3);
    step(3);

    // reset during SERVICE
    ext_irq = 4'b0001; step(4);
    mstatus_mie = 1'b1; mie_meie = 1'b1; step(1);
    check("rs_raise", {31'd0, interrupt}, 32'd1);
    check("rs_cause", irq_cause, 32'h8000_000B);
    trap_ack = 1'b1; step(1); trap_ack = 1'b0;
    check("rs_service", {31'd0, interrupt}, 32'd0);
    ext_irq = '0;
    rst = 1'b1; #2;
    check("rs_async_int", {31'd0, interrupt}, 32'd0);
    check("rs_async_rdata", mmio_rdata, 32'd0);
    check("rs_async_cause", irq_cause, 32'd0);
    step(1);
    rst = 1'b0;
    step(2);
    check("rs_no_pulse", {31'd0, interrupt}, 32'd0);
    rd_check("rs_cmp_lo", 5'h08, 32'hFFFF_FFFF);
    rd_check("rs_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rd_check("rs_pending", 5'h14, 32'd0);
    rd_check("rs_msip", 5'h10, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
